// File: rtl/dffnsnq_bank_seq_pkg.sv
// Shared types and constants for the dffnsnq bank sequencer.
// Holds the sequencer state encoding, the error-counter width and the default bank width.
package dffnsnq_bank_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned ERR_CNT_W     = 8;

    typedef enum logic [1:0] {
        SET_HOLD = 2'd0,
        RECOVER  = 2'd1,
        IDLE     = 2'd2,
        CAPTURE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/dffnsnq_bank_sequencer_sat_err_counter.sv
// Saturating mismatch counter with synchronous clear.
// It holds at all ones once reached, and only the clear input brings it back to zero.
module sat_err_counter
    import dffnsnq_bank_seq_pkg::*;
#(
    parameter int unsigned W = ERR_CNT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_SAT = '1;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_SAT)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dffnsnq_bank_sequencer.sv
// Drives D/SETN of a falling-edge, active-low-set flop bank and checks its Q.
// Presets meet minimum SETN width and recovery; load words arrive over valid/ready.
module dffnsnq_bank_sequencer
    import dffnsnq_bank_seq_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned SET_CYCLES   = 2,
    parameter int unsigned RECOV_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SET_REQ,
    input  logic                 LOAD_VALID,
    input  logic [WIDTH-1:0]     LOAD_DATA,
    output logic                 LOAD_READY,
    output logic [WIDTH-1:0]     BANK_D,
    output logic                 BANK_SETN,
    input  logic [WIDTH-1:0]     BANK_Q,
    output logic                 CHK_VALID,
    output logic                 CHK_ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int unsigned CNT_MAX = (SET_CYCLES > RECOV_CYCLES) ? SET_CYCLES : RECOV_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOV_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONES       = '1;

    seq_state_e       state_q;
    seq_state_e       state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_nxt;
    logic [WIDTH-1:0] bank_d_nxt;
    logic             setn_nxt;
    logic             chk_valid_nxt;
    logic             chk_err_nxt;

    // Next state, cycle counter, expected value and the next values of the registered outputs.
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        exp_nxt       = exp_q;
        chk_valid_nxt = 1'b0;
        chk_err_nxt   = 1'b0;
        LOAD_READY    = 1'b0;

        case (state_q)
            SET_HOLD: begin
                if (cnt_q == SET_LAST) begin
                    state_nxt     = RECOVER;
                    cnt_nxt       = '0;
                    chk_valid_nxt = 1'b1;
                    chk_err_nxt   = (BANK_Q != ONES);
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == RECOV_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                LOAD_READY = !SET_REQ && !RST;
                if (SET_REQ) begin
                    state_nxt = SET_HOLD;
                    cnt_nxt   = '0;
                    exp_nxt   = ONES;
                end else if (LOAD_VALID) begin
                    state_nxt = CAPTURE;
                    exp_nxt   = LOAD_DATA;
                end
            end
            CAPTURE: begin
                state_nxt     = IDLE;
                chk_valid_nxt = 1'b1;
                chk_err_nxt   = (BANK_Q != exp_q);
            end
            default: begin
                state_nxt = SET_HOLD;
                cnt_nxt   = '0;
                exp_nxt   = ONES;
            end
        endcase

        // The bank sees all ones through the whole preset and recovery window.
        setn_nxt   = (state_nxt != SET_HOLD);
        bank_d_nxt = ((state_nxt == SET_HOLD) || (state_nxt == RECOVER)) ? ONES : exp_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= SET_HOLD;
            cnt_q     <= '0;
            exp_q     <= ONES;
            BANK_D    <= ONES;
            BANK_SETN <= 1'b0;
            CHK_VALID <= 1'b0;
            CHK_ERR   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            exp_q     <= exp_nxt;
            BANK_D    <= bank_d_nxt;
            BANK_SETN <= setn_nxt;
            CHK_VALID <= chk_valid_nxt;
            CHK_ERR   <= chk_err_nxt;
        end
    end

    sat_err_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk(CLK),
        .clr(RST),
        .inc(CHK_VALID && CHK_ERR),
        .cnt(ERR_CNT)
    );

endmodule

// File: tb/tb_dffnsnq_bank_sequencer.sv
// Self-checking bench for dffnsnq_bank_sequencer with a behavioural falling-edge set-flop bank.
// Each scenario task drives stimulus and compares against a cycle-count/arithmetic reference.
module tb_dffnsnq_bank_sequencer;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned SET_CYCLES   = 2;
    localparam int unsigned RECOV_CYCLES = 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             SET_REQ;
    logic             LOAD_VALID;
    logic [WIDTH-1:0] LOAD_DATA;
    logic             LOAD_READY;
    logic [WIDTH-1:0] BANK_D;
    logic             BANK_SETN;
    logic [WIDTH-1:0] BANK_Q;
    logic             CHK_VALID;
    logic             CHK_ERR;
    logic [7:0]       ERR_CNT;

    int checks   = 0;
    int failures = 0;
    int model_errs = 0;
    int cyc = 0;

    logic [WIDTH-1:0] bank_ff;
    logic [WIDTH-1:0] stuck_mask = '0;

    dffnsnq_bank_sequencer #(
        .WIDTH(WIDTH),
        .SET_CYCLES(SET_CYCLES),
        .RECOV_CYCLES(RECOV_CYCLES)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SET_REQ(SET_REQ),
        .LOAD_VALID(LOAD_VALID),
        .LOAD_DATA(LOAD_DATA),
        .LOAD_READY(LOAD_READY),
        .BANK_D(BANK_D),
        .BANK_SETN(BANK_SETN),
        .BANK_Q(BANK_Q),
        .CHK_VALID(CHK_VALID),
        .CHK_ERR(CHK_ERR),
        .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural bank: falling-edge capture, asynchronous active-low set, optional stuck-at-0 bits.
    always @(negedge CLK or negedge BANK_SETN) begin
        if (!BANK_SETN) bank_ff <= '1;
        else            bank_ff <= BANK_D;
    end
    assign BANK_Q = bank_ff & ~stuck_mask;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Starts in the first SET_HOLD cycle; walks the preset and recovery windows to IDLE.
    task automatic run_set_sequence(input string tag);
        int n;
        logic exp_err;
        n = 0;
        while (BANK_SETN === 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != SET_CYCLES) begin
            failures++;
            $display("FAIL %s setn_low_cycles: got %0d want %0d", tag, n, SET_CYCLES);
        end
        exp_err = (stuck_mask != '0);
        if (exp_err) model_errs++;
        checks++;
        if (CHK_VALID !== 1'b1 || CHK_ERR !== exp_err) begin
            failures++;
            $display("FAIL %s set_check: valid=%b err=%b want valid=1 err=%b", tag, CHK_VALID, CHK_ERR, exp_err);
        end
        checks++;
        if (BANK_D !== 8'hFF || LOAD_READY !== 1'b0) begin
            failures++;
            $display("FAIL %s recover_outputs: d=%h ready=%b want d=ff ready=0", tag, BANK_D, LOAD_READY);
        end
        n = 0;
        while (LOAD_READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != RECOV_CYCLES) begin
            failures++;
            $display("FAIL %s ready_delay: got %0d want %0d", tag, n, RECOV_CYCLES);
        end
        checks++;
        if (CHK_VALID !== 1'b0 || BANK_SETN !== 1'b1 || ERR_CNT !== sat8(model_errs)) begin
            failures++;
            $display("FAIL %s idle_entry: valid=%b setn=%b cnt=%0d want valid=0 setn=1 cnt=%0d",
                     tag, CHK_VALID, BANK_SETN, ERR_CNT, sat8(model_errs));
        end
    endtask

    // Presents one word from IDLE and checks the capture compare; returns the handshake cycle.
    task automatic do_load(input logic [WIDTH-1:0] data, output int hs_cyc);
        int n;
        logic [WIDTH-1:0] exp_q;
        logic exp_err;
        SET_REQ    = 1'b0;
        LOAD_VALID = 1'b1;
        LOAD_DATA  = data;
        #1;
        n = 0;
        while (LOAD_READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        hs_cyc = -100;
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL load_ready_timeout: ready=%b want 1", LOAD_READY);
            LOAD_VALID = 1'b0;
        end else begin
            tick();
            hs_cyc = cyc;
            LOAD_VALID = 1'b0;
            checks++;
            if (BANK_D !== data || CHK_VALID !== 1'b0) begin
                failures++;
                $display("FAIL load_drive: d=%h valid=%b want d=%h valid=0", BANK_D, CHK_VALID, data);
            end
            tick();
            exp_q   = data & ~stuck_mask;
            exp_err = (exp_q != data);
            if (exp_err) model_errs++;
            checks++;
            if (CHK_VALID !== 1'b1 || CHK_ERR !== exp_err || BANK_Q !== exp_q) begin
                failures++;
                $display("FAIL load_check: valid=%b err=%b q=%h want valid=1 err=%b q=%h",
                         CHK_VALID, CHK_ERR, BANK_Q, exp_err, exp_q);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        SET_REQ = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_DATA = '0;
        tick();
        tick();
        checks++;
        if (BANK_SETN !== 1'b0 || BANK_D !== 8'hFF || CHK_VALID !== 1'b0 || CHK_ERR !== 1'b0
            || ERR_CNT !== 8'd0 || LOAD_READY !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: setn=%b d=%h valid=%b err=%b cnt=%0d ready=%b want 0 ff 0 0 0 0",
                     BANK_SETN, BANK_D, CHK_VALID, CHK_ERR, ERR_CNT, LOAD_READY);
        end
        RST = 1'b0;
        model_errs = 0;
        run_set_sequence("reset_release");
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        do_load(8'hA5, c1);
        do_load(8'h3C, c2);
        checks++;
        if (c2 - c1 != 2) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles want 2", c2 - c1);
        end
        tick();
        checks++;
        if (ERR_CNT !== sat8(model_errs) || BANK_Q !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_hold: cnt=%0d q=%h want cnt=%0d q=3c", ERR_CNT, BANK_Q, sat8(model_errs));
        end
    endtask

    task automatic test_set_priority();
        SET_REQ = 1'b1;
        LOAD_VALID = 1'b1;
        LOAD_DATA = 8'h5A;
        #1;
        checks++;
        if (LOAD_READY !== 1'b0) begin
            failures++;
            $display("FAIL prio_ready: got %b want 0", LOAD_READY);
        end
        tick();
        SET_REQ = 1'b0;
        LOAD_VALID = 1'b0;
        checks++;
        if (BANK_SETN !== 1'b0 || BANK_D !== 8'hFF) begin
            failures++;
            $display("FAIL prio_enter_set: setn=%b d=%h want 0 ff", BANK_SETN, BANK_D);
        end
        run_set_sequence("set_priority");
        tick();
        checks++;
        if (BANK_Q !== 8'hFF) begin
            failures++;
            $display("FAIL prio_bank: q=%h want ff", BANK_Q);
        end
    endtask

    task automatic test_stuck_saturate();
        int c;
        stuck_mask = 8'h08;
        do_load(8'hFF, c);
        tick();
        checks++;
        if (ERR_CNT !== sat8(model_errs) || model_errs != 1) begin
            failures++;
            $display("FAIL stuck_first: cnt=%0d want 1", ERR_CNT);
        end
        for (int i = 0; i < 300; i++) do_load(8'hFF, c);
        tick();
        checks++;
        if (ERR_CNT !== 8'd255) begin
            failures++;
            $display("FAIL stuck_saturate: cnt=%0d want 255", ERR_CNT);
        end
        stuck_mask = '0;
    endtask

    task automatic test_rst_capture();
        int n;
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 8'hC3;
        #1;
        n = 0;
        while (LOAD_READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        LOAD_VALID = 1'b0;
        RST = 1'b1;
        tick();
        checks++;
        if (CHK_VALID !== 1'b0 || BANK_SETN !== 1'b0 || ERR_CNT !== 8'd0 || BANK_D !== 8'hFF) begin
            failures++;
            $display("FAIL rst_capture: valid=%b setn=%b cnt=%0d d=%h want 0 0 0 ff",
                     CHK_VALID, BANK_SETN, ERR_CNT, BANK_D);
        end
        RST = 1'b0;
        model_errs = 0;
        run_set_sequence("rst_replay");
    endtask

    task automatic test_set_in_recover();
        int n;
        int lows;
        SET_REQ = 1'b1;
        tick();
        SET_REQ = 1'b0;
        n = 0;
        while (BANK_SETN !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        SET_REQ = 1'b1;
        tick();
        SET_REQ = 1'b0;
        #1;
        checks++;
        if (LOAD_READY !== 1'b1 || BANK_SETN !== 1'b1) begin
            failures++;
            $display("FAIL recover_ignore: ready=%b setn=%b want 1 1", LOAD_READY, BANK_SETN);
        end
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (BANK_SETN !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL recover_no_extra_set: setn low %0d cycles want 0", lows);
        end
    endtask

    task automatic test_random();
        int c;
        for (int it = 0; it < 40; it++) begin
            stuck_mask = ($urandom_range(3) == 0) ? WIDTH'(1 << $urandom_range(7)) : '0;
            if ($urandom_range(4) == 0) begin
                SET_REQ = 1'b1;
                LOAD_VALID = 1'($urandom_range(1));
                LOAD_DATA = 8'($urandom);
                #1;
                checks++;
                if (LOAD_READY !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_set_ready: got %b want 0", LOAD_READY);
                end
                tick();
                SET_REQ = 1'b0;
                LOAD_VALID = 1'b0;
                run_set_sequence("rand_set");
            end else begin
                do_load(8'($urandom), c);
            end
            tick();
            checks++;
            if (ERR_CNT !== sat8(model_errs)) begin
                failures++;
                $display("FAIL rand_err_cnt: got %0d want %0d", ERR_CNT, sat8(model_errs));
            end
        end
        stuck_mask = '0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_set_priority();
        test_stuck_saturate();
        test_rst_capture();
        test_set_in_recover();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dffnsnq_bank_sequencer.md
# dffnsnq_bank_sequencer

Control stage that sits directly upstream of a bank of WIDTH negative-edge, active-low-set flops (dffnsnq family) and drives their D and SETN pins, then reads their Q back for self-check. It sequences preset pulses that meet minimum SETN width and recovery, and accepts load words over a valid/ready handshake. It compares bank output against the expected value after every set or load and counts mismatches. The bank is clocked by the same CLK, so it captures on the falling edge. This block runs on the rising edge.

## Interface
- WIDTH, 8: bank width in bits.
- SET_CYCLES, 2: cycles SETN is held low per preset (≥1).
- RECOV_CYCLES, 1: cycles after SETN release before any load may be accepted (≥1).

- CLK  input  1  clock; the bank's CLKN pin is tied to this same net.
- RST  input  1  synchronous, active-high reset.
- SET_REQ  input  1  request a bank preset.
- LOAD_VALID  input  1  load word valid.
- LOAD_DATA  input  WIDTH  load word.
- LOAD_READY  output  1  load word accepted when LOAD_VALID && LOAD_READY at rising CLK.
- BANK_D  output  WIDTH  to bank D pins.
- BANK_SETN  output  1  to all bank SETN pins.
- BANK_Q  input  WIDTH  from bank Q pins.
- CHK_VALID  output  1  one-cycle pulse; a compare result is present.
- CHK_ERR  output  1  mismatch flag, qualified by CHK_VALID.
- ERR_CNT  output  8  saturating mismatch count.

## Operation
- States: SET_HOLD, RECOVER, IDLE, CAPTURE. The expected register EXP holds the value the bank should contain.
- **RST** (any state, mid-operation included): next state SET_HOLD and counter cleared.
  - Register values: BANK_SETN=0, BANK_D=all ones, EXP=all ones, CHK_VALID=0, CHK_ERR=0, ERR_CNT=0.
  - LOAD_READY=0 while in reset.
- **SET_HOLD:** BANK_SETN=0 and BANK_D=all ones.
  - Stays for SET_CYCLES cycles, then goes to RECOVER.
  - On that transition: compare BANK_Q against all ones, pulse CHK_VALID, CHK_ERR=(BANK_Q!=all ones).
- **RECOVER:** BANK_SETN=1 and BANK_D=all ones.
  - Stays for RECOV_CYCLES cycles, then goes to IDLE.
- **IDLE:** BANK_D=EXP, so falling edges recapture the same value.
  - LOAD_READY = !SET_REQ (combinational).
  - If SET_REQ=1: go to SET_HOLD and set EXP=all ones. SET_REQ wins over a simultaneous LOAD_VALID, which is not accepted.
  - Else on handshake: BANK_D<=LOAD_DATA, EXP<=LOAD_DATA, go to CAPTURE.
- **CAPTURE:** the bank captures BANK_D on the falling edge inside this cycle.
  - At the closing rising edge: compare BANK_Q with EXP, pulse CHK_VALID, set CHK_ERR, go to IDLE.
- SET_REQ outside IDLE is ignored and not queued.
- **ERR_CNT:** increments on CHK_VALID && CHK_ERR and saturates at 255. Only RST clears it.

## Timing
- Outputs are registered, except LOAD_READY.
- After RST deasserts:
  - BANK_SETN stays low SET_CYCLES cycles, then high.
  - First LOAD_READY=1 appears RECOV_CYCLES cycles later.
- Load throughput: one word per 2 cycles (handshake cycle, then CAPTURE). CHK_VALID rises on the edge ending CAPTURE and is high in the cycle after it.
- Setup margin: BANK_D changes only on rising CLK, giving the bank half a cycle of D setup and half a cycle of hold.
- Recovery/removal: at least RECOV_CYCLES full cycles separate the SETN rising edge from the first capture of non-all-ones data. Bank D is all ones throughout RECOVER.
- Minimum SETN low width: SET_CYCLES full cycles.

## Structure
- Package dffnsnq_bank_seq_pkg holds:
  - the state enum (SET_HOLD, RECOVER, IDLE, CAPTURE);
  - the ERR_CNT width constant (8);
  - default WIDTH.
- One sub-module, sat_err_counter: an 8-bit saturating increment with synchronous clear.
- The state/cycle counter stays in the top level; it is sized to the larger of SET_CYCLES and RECOV_CYCLES.

## Test plan
- Reset release with WIDTH=8, SET_CYCLES=2, RECOV_CYCLES=1 and a behavioural bank model -> SETN low 2 cycles; CHK_VALID with CHK_ERR=0; LOAD_READY high 1 cycle after SETN rises.
- Load 0xA5, then load 0x3C back-to-back -> each word is accepted every 2nd cycle; BANK_Q=0xA5 then 0x3C; two CHK_VALID pulses, both with CHK_ERR=0.
- SET_REQ and LOAD_VALID asserted together in IDLE -> LOAD_READY=0, word not taken, SETN low 2 cycles, bank reads 0xFF.
- Bank model stuck-at-0 on bit 3, load 0xFF -> CHK_ERR=1 and ERR_CNT=1; 300 such loads -> ERR_CNT saturates at 255.
- RST asserted during CAPTURE -> no CHK_VALID pulse; SETN=0 next cycle; ERR_CNT=0; the full set sequence replays.
- SET_REQ pulsed during RECOVER -> ignored; no extra SET_HOLD occurs.
